// File: rtl/load_store_buffer.sv
// In-order load/store queue: snoops the ALU and its own ls_cdb for operands,
// issues the head entry to memory, and broadcasts load results on ls_cdb.
module load_store_buffer #(
  parameter int LSB_SIZE      = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_WIDTH     = 4,
  parameter int OPERATION_BUS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     dispatch_ena,
  input  logic [OPERATION_BUS-1:0] in_op,
  input  logic [ROB_WIDTH-1:0]     in_Qj,
  input  logic [ROB_WIDTH-1:0]     in_Qk,
  input  logic [DATA_WIDTH-1:0]    in_Vj,
  input  logic [DATA_WIDTH-1:0]    in_Vk,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [ROB_WIDTH-1:0]     in_rd_rob,
  input  logic [ROB_WIDTH-1:0]     in_alu_cdb_rob_tag,
  input  logic [DATA_WIDTH-1:0]    in_alu_cdb_data,
  input  logic [ROB_WIDTH-1:0]     in_commit_rob_tag,
  input  logic                     in_clear,
  output logic                     out_mem_req,
  output logic                     out_mem_we,
  output logic [DATA_WIDTH-1:0]    out_mem_addr,
  output logic [1:0]               out_mem_size,
  output logic [DATA_WIDTH-1:0]    out_mem_wdata,
  input  logic                     in_mem_done,
  input  logic [DATA_WIDTH-1:0]    in_mem_rdata,
  output logic [ROB_WIDTH-1:0]     out_ls_cdb_rob_tag,
  output logic [DATA_WIDTH-1:0]    out_ls_cdb_data,
  output logic                     has_capacity
);

  localparam int PTR_W = $clog2(LSB_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSB_SIZE);
  localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(LSB_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  localparam logic [OPERATION_BUS-1:0] OP_LB  = OPERATION_BUS'(0);
  localparam logic [OPERATION_BUS-1:0] OP_LH  = OPERATION_BUS'(1);
  localparam logic [OPERATION_BUS-1:0] OP_LW  = OPERATION_BUS'(2);
  localparam logic [OPERATION_BUS-1:0] OP_LBU = OPERATION_BUS'(3);
  localparam logic [OPERATION_BUS-1:0] OP_LHU = OPERATION_BUS'(4);
  localparam logic [OPERATION_BUS-1:0] OP_SB  = OPERATION_BUS'(5);
  localparam logic [OPERATION_BUS-1:0] OP_SH  = OPERATION_BUS'(6);
  localparam logic [OPERATION_BUS-1:0] OP_SW  = OPERATION_BUS'(7);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  logic                     busy_q      [LSB_SIZE];
  logic                     busy_d      [LSB_SIZE];
  logic                     committed_q [LSB_SIZE];
  logic                     committed_d [LSB_SIZE];
  logic [OPERATION_BUS-1:0] op_q        [LSB_SIZE];
  logic [OPERATION_BUS-1:0] op_d        [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     qj_q        [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     qj_d        [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     qk_q        [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     qk_d        [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     rob_q       [LSB_SIZE];
  logic [ROB_WIDTH-1:0]     rob_d       [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    vj_q        [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    vj_d        [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    vk_q        [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    vk_d        [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    imm_q       [LSB_SIZE];
  logic [DATA_WIDTH-1:0]    imm_d       [LSB_SIZE];

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d, committed_cnt;
  state_t                state_q, state_d;
  logic                  req_q, req_d, we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic [ROB_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic                  load_killed_q, load_killed_d;
  logic                  head_store, head_ready, pop, dispatch_ok, load_live;

  function automatic logic is_store(input logic [OPERATION_BUS-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  assign head_store = is_store(op_q[head_q]);
  assign head_ready = busy_q[head_q] && (qj_q[head_q] == ZERO_ROB) &&
                      (!head_store || ((qk_q[head_q] == ZERO_ROB) && committed_q[head_q]));
  assign has_capacity       = count_q < CAP_CNT;
  assign out_mem_req        = req_q;
  assign out_mem_we         = we_q;
  assign out_mem_addr       = addr_q;
  assign out_mem_size       = size_q;
  assign out_mem_wdata      = wdata_q;
  assign out_ls_cdb_rob_tag = cdb_tag_q;
  assign out_ls_cdb_data    = cdb_data_q;

  always_comb begin
    busy_d = busy_q;  committed_d = committed_q;  op_d = op_q;  rob_d = rob_q;
    qj_d = qj_q;  qk_d = qk_q;  vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;  state_d = state_q;
    req_d = req_q;  we_d = we_q;  addr_d = addr_q;  size_d = size_q;  wdata_d = wdata_q;
    cdb_tag_d = ZERO_ROB;  cdb_data_d = '0;  load_killed_d = load_killed_q;
    pop = 1'b0;  load_live = 1'b0;  committed_cnt = '0;
    dispatch_ok = dispatch_ena && !in_clear && (count_q < FULL_CNT);

    // Operand snooping on both CDBs plus commit marking, per busy entry.
    for (int i = 0; i < LSB_SIZE; i++) begin
      if (busy_q[i]) begin
        if (qj_q[i] != ZERO_ROB && qj_q[i] == in_alu_cdb_rob_tag) begin
          qj_d[i] = ZERO_ROB;  vj_d[i] = in_alu_cdb_data;
        end else if (qj_q[i] != ZERO_ROB && qj_q[i] == cdb_tag_q) begin
          qj_d[i] = ZERO_ROB;  vj_d[i] = cdb_data_q;
        end
        if (qk_q[i] != ZERO_ROB && qk_q[i] == in_alu_cdb_rob_tag) begin
          qk_d[i] = ZERO_ROB;  vk_d[i] = in_alu_cdb_data;
        end else if (qk_q[i] != ZERO_ROB && qk_q[i] == cdb_tag_q) begin
          qk_d[i] = ZERO_ROB;  vk_d[i] = cdb_data_q;
        end
        if (is_store(op_q[i]) && in_commit_rob_tag != ZERO_ROB && rob_q[i] == in_commit_rob_tag)
          committed_d[i] = 1'b1;
        if (committed_d[i])
          committed_cnt = committed_cnt + ONE_CNT;
      end
    end

    case (state_q)
      IDLE: begin
        // A load about to be flushed must not start an access.
        if (head_ready && !(in_clear && !head_store)) begin
          req_d   = 1'b1;
          we_d    = head_store;
          addr_d  = vj_q[head_q] + imm_q[head_q];
          wdata_d = vk_q[head_q];
          case (op_q[head_q])
            OP_LB, OP_LBU, OP_SB: size_d = 2'd0;
            OP_LH, OP_LHU, OP_SH: size_d = 2'd1;
            default:              size_d = 2'd2;
          endcase
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        load_live = !we_q && !load_killed_q && !in_clear;
        if (in_mem_done) begin
          req_d = 1'b0;  state_d = IDLE;  load_killed_d = 1'b0;
          pop = we_q || load_live;
          if (load_live) begin
            cdb_tag_d = rob_q[head_q];
            case (op_q[head_q])
              OP_LB:   cdb_data_d = {{(DATA_WIDTH-8){in_mem_rdata[7]}}, in_mem_rdata[7:0]};
              OP_LH:   cdb_data_d = {{(DATA_WIDTH-16){in_mem_rdata[15]}}, in_mem_rdata[15:0]};
              OP_LBU:  cdb_data_d = {{(DATA_WIDTH-8){1'b0}}, in_mem_rdata[7:0]};
              OP_LHU:  cdb_data_d = {{(DATA_WIDTH-16){1'b0}}, in_mem_rdata[15:0]};
              default: cdb_data_d = in_mem_rdata;
            endcase
          end
        end else if (in_clear && !we_q) begin
          load_killed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      busy_d[head_q] = 1'b0;  committed_d[head_q] = 1'b0;
      head_d = head_q + ONE_PTR;
    end

    // Flush keeps only the committed prefix; the tail is rebuilt from the old head.
    if (in_clear) begin
      for (int i = 0; i < LSB_SIZE; i++)
        busy_d[i] = busy_d[i] && committed_d[i];
      tail_d  = head_q + committed_cnt[PTR_W-1:0];
      count_d = committed_cnt - (pop ? ONE_CNT : '0);
    end else begin
      if (dispatch_ok) begin
        busy_d[tail_q] = 1'b1;  committed_d[tail_q] = 1'b0;
        op_d[tail_q] = in_op;  rob_d[tail_q] = in_rd_rob;  imm_d[tail_q] = in_imm;
        if (in_Qj != ZERO_ROB && in_Qj == in_alu_cdb_rob_tag) begin
          qj_d[tail_q] = ZERO_ROB;  vj_d[tail_q] = in_alu_cdb_data;
        end else if (in_Qj != ZERO_ROB && in_Qj == cdb_tag_q) begin
          qj_d[tail_q] = ZERO_ROB;  vj_d[tail_q] = cdb_data_q;
        end else begin
          qj_d[tail_q] = in_Qj;  vj_d[tail_q] = in_Vj;
        end
        if (in_Qk != ZERO_ROB && in_Qk == in_alu_cdb_rob_tag) begin
          qk_d[tail_q] = ZERO_ROB;  vk_d[tail_q] = in_alu_cdb_data;
        end else if (in_Qk != ZERO_ROB && in_Qk == cdb_tag_q) begin
          qk_d[tail_q] = ZERO_ROB;  vk_d[tail_q] = cdb_data_q;
        end else begin
          qk_d[tail_q] = in_Qk;  vk_d[tail_q] = in_Vk;
        end
        tail_d = tail_q + ONE_PTR;
      end
      count_d = count_q + (dispatch_ok ? ONE_CNT : '0) - (pop ? ONE_CNT : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        busy_q[i] <= 1'b0;  committed_q[i] <= 1'b0;  op_q[i] <= '0;  rob_q[i] <= '0;
        qj_q[i] <= '0;  qk_q[i] <= '0;  vj_q[i] <= '0;  vk_q[i] <= '0;  imm_q[i] <= '0;
      end
      head_q <= '0;  tail_q <= '0;  count_q <= '0;  state_q <= IDLE;
      req_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  size_q <= '0;  wdata_q <= '0;
      cdb_tag_q <= ZERO_ROB;  cdb_data_q <= '0;  load_killed_q <= 1'b0;
    end else if (ena) begin
      busy_q <= busy_d;  committed_q <= committed_d;  op_q <= op_d;  rob_q <= rob_d;
      qj_q <= qj_d;  qk_q <= qk_d;  vj_q <= vj_d;  vk_q <= vk_d;  imm_q <= imm_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;  state_q <= state_d;
      req_q <= req_d;  we_q <= we_d;  addr_q <= addr_d;  size_q <= size_d;  wdata_q <= wdata_d;
      cdb_tag_q <= cdb_tag_d;  cdb_data_q <= cdb_data_d;  load_killed_q <= load_killed_d;
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer: one task per scenario.
module tb_load_store_buffer;

  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
  localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7;

  logic        clk = 1'b0;
  logic        rst, ena, dispatch_ena, in_clear, in_mem_done;
  logic [3:0]  in_op, in_Qj, in_Qk, in_rd_rob, in_alu_cdb_rob_tag, in_commit_rob_tag;
  logic [31:0] in_Vj, in_Vk, in_imm, in_alu_cdb_data, in_mem_rdata;
  logic        out_mem_req, out_mem_we, has_capacity;
  logic [31:0] out_mem_addr, out_mem_wdata, out_ls_cdb_data;
  logic [1:0]  out_mem_size;
  logic [3:0]  out_ls_cdb_rob_tag;

  int compared = 0;
  int mismatched = 0;

  load_store_buffer dut (
    .clk(clk), .rst(rst), .ena(ena), .dispatch_ena(dispatch_ena), .in_op(in_op),
    .in_Qj(in_Qj), .in_Qk(in_Qk), .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm),
    .in_rd_rob(in_rd_rob), .in_alu_cdb_rob_tag(in_alu_cdb_rob_tag),
    .in_alu_cdb_data(in_alu_cdb_data), .in_commit_rob_tag(in_commit_rob_tag),
    .in_clear(in_clear), .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
    .out_mem_addr(out_mem_addr), .out_mem_size(out_mem_size), .out_mem_wdata(out_mem_wdata),
    .in_mem_done(in_mem_done), .in_mem_rdata(in_mem_rdata),
    .out_ls_cdb_rob_tag(out_ls_cdb_rob_tag), .out_ls_cdb_data(out_ls_cdb_data),
    .has_capacity(has_capacity)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [3:0] qj, input logic [31:0] vj,
                          input logic [3:0] qk, input logic [31:0] vk,
                          input logic [31:0] imm, input logic [3:0] rob);
    in_op = op; in_Qj = qj; in_Vj = vj; in_Qk = qk; in_Vk = vk; in_imm = imm; in_rd_rob = rob;
    dispatch_ena = 1'b1;
    tick();
    dispatch_ena = 1'b0; in_Qj = 4'd0; in_Qk = 4'd0;
  endtask

  task automatic mem_done(input logic [31:0] d);
    in_mem_done = 1'b1; in_mem_rdata = d;
    tick();
    in_mem_done = 1'b0; in_mem_rdata = 32'd0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (out_mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    compared++;
    if ({out_mem_req, out_mem_we, out_mem_size} !== 4'b0 || out_mem_addr !== 32'd0 || out_mem_wdata !== 32'd0) begin
      mismatched++; $display("[TB] FAIL reset_mem got req=%b we=%b size=%0d addr=%h wdata=%h expected all 0", out_mem_req, out_mem_we, out_mem_size, out_mem_addr, out_mem_wdata);
    end
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd0 || out_ls_cdb_data !== 32'd0 || has_capacity !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_cdb got tag=%0d data=%h cap=%b expected 0/0/1", out_ls_cdb_rob_tag, out_ls_cdb_data, has_capacity);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    int n;
    dispatch(LW, 4'd0, 32'h100, 4'd0, 32'd0, 32'd4, 4'd3);
    compared++;
    if (out_mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL lw_req_early got %b expected 0", out_mem_req); end
    tick();
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_we !== 1'b0 || out_mem_addr !== 32'h104 || out_mem_size !== 2'd2) begin
      mismatched++; $display("[TB] FAIL lw_issue got req=%b we=%b addr=%h size=%0d expected 1/0/104/2", out_mem_req, out_mem_we, out_mem_addr, out_mem_size);
    end
    tick(); tick();
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h104) begin
      mismatched++; $display("[TB] FAIL lw_hold got req=%b addr=%h expected 1/104", out_mem_req, out_mem_addr);
    end
    mem_done(32'hDEADBEEF);
    compared++;
    if (out_mem_req !== 1'b0 || out_ls_cdb_rob_tag !== 4'd3 || out_ls_cdb_data !== 32'hDEADBEEF) begin
      mismatched++; $display("[TB] FAIL lw_bcast got req=%b tag=%0d data=%h expected 0/3/deadbeef", out_mem_req, out_ls_cdb_rob_tag, out_ls_cdb_data);
    end
    tick();
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd0) begin mismatched++; $display("[TB] FAIL lw_bcast_len got tag=%0d expected 0", out_ls_cdb_rob_tag); end
    n = 0;
  endtask

  task automatic test_extend();
    logic [3:0]  ops  [4] = '{LB, LBU, LH, LHU};
    logic [31:0] rd   [4] = '{32'h80, 32'h80, 32'h8001, 32'h8001};
    logic [31:0] exp_d[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    logic [1:0]  exp_s[4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    int n;
    for (int i = 0; i < 4; i++) begin
      dispatch(ops[i], 4'd0, 32'h200, 4'd0, 32'd0, 32'(i), 4'(i + 1));
      wait_req(n);
      compared++;
      if (out_mem_req !== 1'b1 || out_mem_size !== exp_s[i] || out_mem_addr !== 32'h200 + 32'(i)) begin
        mismatched++; $display("[TB] FAIL ext_issue[%0d] got req=%b size=%0d addr=%h expected 1/%0d/%h", i, out_mem_req, out_mem_size, out_mem_addr, exp_s[i], 32'h200 + 32'(i));
      end
      mem_done(rd[i]);
      compared++;
      if (out_ls_cdb_rob_tag !== 4'(i + 1) || out_ls_cdb_data !== exp_d[i]) begin
        mismatched++; $display("[TB] FAIL ext_data[%0d] got tag=%0d data=%h expected %0d/%h", i, out_ls_cdb_rob_tag, out_ls_cdb_data, i + 1, exp_d[i]);
      end
    end
  endtask

  task automatic test_store_gating();
    int n;
    dispatch(SW, 4'd0, 32'h300, 4'd0, 32'h12345678, 32'd8, 4'd5);
    tick(); tick(); tick();
    compared++;
    if (out_mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_uncommitted got req=%b expected 0", out_mem_req); end
    in_commit_rob_tag = 4'd5;
    tick();
    in_commit_rob_tag = 4'd0;
    compared++;
    if (out_mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL sw_commit_same_cycle got req=%b expected 0", out_mem_req); end
    tick();
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_we !== 1'b1 || out_mem_addr !== 32'h308 || out_mem_wdata !== 32'h12345678 || out_mem_size !== 2'd2) begin
      mismatched++; $display("[TB] FAIL sw_issue got req=%b we=%b addr=%h wdata=%h size=%0d expected 1/1/308/12345678/2", out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_size);
    end
    mem_done(32'h0);
    compared++;
    if (out_mem_req !== 1'b0 || out_ls_cdb_rob_tag !== 4'd0 || dut.count_q !== 4'd0) begin
      mismatched++; $display("[TB] FAIL sw_done got req=%b tag=%0d count=%0d expected 0/0/0", out_mem_req, out_ls_cdb_rob_tag, dut.count_q);
    end
    n = 0;
  endtask

  task automatic test_dependency();
    int n;
    dispatch(LW, 4'd0, 32'h400, 4'd0, 32'd0, 32'd0, 4'd7);
    dispatch(SW, 4'd0, 32'h500, 4'd7, 32'd0, 32'd0, 4'd8);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_we !== 1'b0 || out_mem_addr !== 32'h400) begin
      mismatched++; $display("[TB] FAIL dep_lw got req=%b we=%b addr=%h expected 1/0/400", out_mem_req, out_mem_we, out_mem_addr);
    end
    mem_done(32'hCAFEF00D);
    in_commit_rob_tag = 4'd8;
    tick();
    in_commit_rob_tag = 4'd0;
    wait_req(n);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_we !== 1'b1 || out_mem_addr !== 32'h500 || out_mem_wdata !== 32'hCAFEF00D || n != 1) begin
      mismatched++; $display("[TB] FAIL dep_sw got req=%b we=%b addr=%h wdata=%h wait=%0d expected 1/1/500/cafef00d/1", out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, n);
    end
    mem_done(32'h0);
  endtask

  task automatic test_back_to_back();
    int n;
    dispatch(LW, 4'd0, 32'h900, 4'd0, 32'd0, 32'd0, 4'd11);
    dispatch(LW, 4'd0, 32'h904, 4'd0, 32'd0, 32'd0, 4'd12);
    mem_done(32'h1);
    compared++;
    if (out_mem_req !== 1'b0 || out_ls_cdb_rob_tag !== 4'd11) begin
      mismatched++; $display("[TB] FAIL b2b_gap got req=%b tag=%0d expected 0/11", out_mem_req, out_ls_cdb_rob_tag);
    end
    tick();
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h904) begin
      mismatched++; $display("[TB] FAIL b2b_second got req=%b addr=%h expected 1/904", out_mem_req, out_mem_addr);
    end
    mem_done(32'h2);
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd12 || out_ls_cdb_data !== 32'h2) begin
      mismatched++; $display("[TB] FAIL b2b_bcast got tag=%0d data=%h expected 12/2", out_ls_cdb_rob_tag, out_ls_cdb_data);
    end
    n = 0;
  endtask

  task automatic test_alu_snoop();
    int n;
    dispatch(LW, 4'd6, 32'h0, 4'd0, 32'd0, 32'd4, 4'd13);
    tick(); tick();
    compared++;
    if (out_mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL snoop_wait got req=%b expected 0", out_mem_req); end
    in_alu_cdb_rob_tag = 4'd6; in_alu_cdb_data = 32'hA00;
    tick();
    in_alu_cdb_rob_tag = 4'd0; in_alu_cdb_data = 32'd0;
    wait_req(n);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'hA04) begin
      mismatched++; $display("[TB] FAIL snoop_addr got req=%b addr=%h expected 1/a04", out_mem_req, out_mem_addr);
    end
    mem_done(32'h0);
    in_alu_cdb_rob_tag = 4'd6; in_alu_cdb_data = 32'hB00;
    dispatch(LW, 4'd6, 32'h0, 4'd0, 32'd0, 32'd8, 4'd14);
    in_alu_cdb_rob_tag = 4'd0; in_alu_cdb_data = 32'd0;
    tick();
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'hB08) begin
      mismatched++; $display("[TB] FAIL snoop_dispatch got req=%b addr=%h expected 1/b08", out_mem_req, out_mem_addr);
    end
    mem_done(32'h0);
  endtask

  task automatic test_flush();
    int n, leaked;
    dispatch(SB, 4'd0, 32'h600, 4'd0, 32'hAB, 32'd1, 4'd1);
    in_commit_rob_tag = 4'd1;
    dispatch(LW, 4'd0, 32'h700, 4'd0, 32'd0, 32'd0, 4'd2);
    in_commit_rob_tag = 4'd0;
    dispatch(LH, 4'd0, 32'h702, 4'd0, 32'd0, 32'd0, 4'd3);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_we !== 1'b1 || out_mem_addr !== 32'h601 || out_mem_size !== 2'd0 || out_mem_wdata !== 32'hAB) begin
      mismatched++; $display("[TB] FAIL flush_sb_issue got req=%b we=%b addr=%h size=%0d wdata=%h expected 1/1/601/0/ab", out_mem_req, out_mem_we, out_mem_addr, out_mem_size, out_mem_wdata);
    end
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
    compared++;
    if (dut.count_q !== 4'd1 || out_mem_req !== 1'b1) begin
      mismatched++; $display("[TB] FAIL flush_count got count=%0d req=%b expected 1/1", dut.count_q, out_mem_req);
    end
    mem_done(32'h0);
    leaked = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_mem_req !== 1'b0 || out_ls_cdb_rob_tag !== 4'd0) leaked++;
      tick();
    end
    compared++;
    if (leaked != 0 || dut.count_q !== 4'd0) begin
      mismatched++; $display("[TB] FAIL flush_discard got leaked_cycles=%0d count=%0d expected 0/0", leaked, dut.count_q);
    end
    dispatch(LW, 4'd0, 32'h800, 4'd0, 32'd0, 32'd0, 4'd9);
    wait_req(n);
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
    compared++;
    if (out_mem_req !== 1'b1 || dut.count_q !== 4'd0) begin
      mismatched++; $display("[TB] FAIL flush_lw_hold got req=%b count=%0d expected 1/0", out_mem_req, dut.count_q);
    end
    mem_done(32'h11111111);
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd0 || dut.count_q !== 4'd0 || out_mem_req !== 1'b0) begin
      mismatched++; $display("[TB] FAIL flush_lw_bcast got tag=%0d count=%0d req=%b expected 0/0/0", out_ls_cdb_rob_tag, dut.count_q, out_mem_req);
    end
    dispatch(LW, 4'd0, 32'h880, 4'd0, 32'd0, 32'd0, 4'd10);
    wait_req(n);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h880) begin
      mismatched++; $display("[TB] FAIL flush_after_addr got req=%b addr=%h expected 1/880", out_mem_req, out_mem_addr);
    end
    mem_done(32'h5);
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd10 || out_ls_cdb_data !== 32'h5) begin
      mismatched++; $display("[TB] FAIL flush_after_bcast got tag=%0d data=%h expected 10/5", out_ls_cdb_rob_tag, out_ls_cdb_data);
    end
  endtask

  task automatic test_capacity();
    int n;
    for (int i = 1; i <= 6; i++) dispatch(SW, 4'd0, 32'd0, 4'd0, 32'(i), 32'(i * 4), 4'(i));
    compared++;
    if (has_capacity !== 1'b1) begin mismatched++; $display("[TB] FAIL cap_six got %b expected 1", has_capacity); end
    dispatch(SW, 4'd0, 32'd0, 4'd0, 32'd7, 32'd28, 4'd7);
    compared++;
    if (has_capacity !== 1'b0) begin mismatched++; $display("[TB] FAIL cap_seven got %b expected 0", has_capacity); end
    in_commit_rob_tag = 4'd1;
    tick();
    in_commit_rob_tag = 4'd0;
    wait_req(n);
    compared++;
    if (out_mem_req !== 1'b1 || out_mem_addr !== 32'd4 || out_mem_wdata !== 32'd1) begin
      mismatched++; $display("[TB] FAIL cap_pop_issue got req=%b addr=%h wdata=%h expected 1/4/1", out_mem_req, out_mem_addr, out_mem_wdata);
    end
    mem_done(32'h0);
    compared++;
    if (has_capacity !== 1'b1) begin mismatched++; $display("[TB] FAIL cap_after_pop got %b expected 1", has_capacity); end
    dispatch(SW, 4'd0, 32'd0, 4'd0, 32'd8, 32'd0, 4'd8);
    dispatch(SW, 4'd0, 32'd0, 4'd0, 32'd9, 32'd0, 4'd9);
    dispatch(SW, 4'd0, 32'd0, 4'd0, 32'd10, 32'd0, 4'd10);
    compared++;
    if (dut.count_q !== 4'd8 || has_capacity !== 1'b0) begin
      mismatched++; $display("[TB] FAIL cap_full got count=%0d cap=%b expected 8/0", dut.count_q, has_capacity);
    end
    in_clear = 1'b1;
    tick();
    in_clear = 1'b0;
    compared++;
    if (dut.count_q !== 4'd0 || has_capacity !== 1'b1) begin
      mismatched++; $display("[TB] FAIL cap_clear got count=%0d cap=%b expected 0/1", dut.count_q, has_capacity);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [3:0]  tag;
    logic [31:0] rd;
    for (int i = 0; i < 20; i++) begin
      tag = 4'((i % 15) + 1);
      rd  = 32'(i) * 32'h01010101 + 32'd1;
      dispatch(LW, 4'd0, 32'h1000 + 32'(i * 16), 4'd0, 32'd0, 32'(i), tag);
      wait_req(n);
      compared++;
      if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h1000 + 32'(i * 16) + 32'(i)) begin
        mismatched++; $display("[TB] FAIL wrap_addr[%0d] got req=%b addr=%h expected 1/%h", i, out_mem_req, out_mem_addr, 32'h1000 + 32'(i * 16) + 32'(i));
      end
      mem_done(rd);
      compared++;
      if (out_ls_cdb_rob_tag !== tag || out_ls_cdb_data !== rd) begin
        mismatched++; $display("[TB] FAIL wrap_bcast[%0d] got tag=%0d data=%h expected %0d/%h", i, out_ls_cdb_rob_tag, out_ls_cdb_data, tag, rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    dispatch(LW, 4'd0, 32'hC00, 4'd0, 32'd0, 32'd0, 4'd15);
    wait_req(n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (out_mem_req !== 1'b0 || out_mem_addr !== 32'd0) begin
      mismatched++; $display("[TB] FAIL rstmid_req got req=%b addr=%h expected 0/0", out_mem_req, out_mem_addr);
    end
    mem_done(32'h77);
    compared++;
    if (out_ls_cdb_rob_tag !== 4'd0 || out_mem_req !== 1'b0 || dut.count_q !== 4'd0) begin
      mismatched++; $display("[TB] FAIL rstmid_done got tag=%0d req=%b count=%0d expected 0/0/0", out_ls_cdb_rob_tag, out_mem_req, dut.count_q);
    end
  endtask

  task automatic test_enable();
    ena = 1'b0;
    dispatch(LW, 4'd0, 32'hD00, 4'd0, 32'd0, 32'd0, 4'd3);
    tick();
    ena = 1'b1;
    tick();
    compared++;
    if (dut.count_q !== 4'd0 || out_mem_req !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ena_freeze got count=%0d req=%b expected 0/0", dut.count_q, out_mem_req);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; dispatch_ena = 1'b0; in_clear = 1'b0; in_mem_done = 1'b0;
    in_op = 4'd0; in_Qj = 4'd0; in_Qk = 4'd0; in_rd_rob = 4'd0;
    in_alu_cdb_rob_tag = 4'd0; in_commit_rob_tag = 4'd0;
    in_Vj = 32'd0; in_Vk = 32'd0; in_imm = 32'd0; in_alu_cdb_data = 32'd0; in_mem_rdata = 32'd0;
    test_reset();
    test_load_word();
    test_extend();
    test_store_gating();
    test_dependency();
    test_back_to_back();
    test_alu_snoop();
    test_flush();
    test_capacity();
    test_wrap();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
